// File: rtl/psd_pkg.sv
// Shared types and sizing helpers for the PSD baseline tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package psd_pkg;

    localparam int DATA_W_DEF   = 20;
    localparam int AVG_LOG2_DEF = 4;
    localparam int HOLDOFF_DEF  = 512;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Accumulator width: DATA_W plus one bit per doubling of the block size,
    // so a full block of maximum-valued samples cannot overflow.
    function automatic int acc_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter that wraps to 1 after reaching rollover_val, with a registered rollover flag.
// Latency: count_out and rollover_flag update on the clock edge after count_enable.
// Backpressure: none; clear has priority over count_enable.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;

    // Next count: clear wins, otherwise step and wrap back to 1 after the rollover value.
    always_comb begin
        count_d = count_q;
        flag_d  = flag_q;
        if (clear) begin
            count_d = '0;
            flag_d  = 1'b0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
            flag_d = (count_d == rollover_val);
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;

endmodule

// File: rtl/psd_baseline_tracker.sv
// Block-average baseline estimator with pulse trigger and post-pulse holdoff.
// Latency: baseline_value 1 cycle after the block-completing sample; pulse_start 1 cycle after the trigger sample.
// Backpressure: none; samples arriving during HOLD are dropped, sample_valid low simply stalls accumulation.
module psd_baseline_tracker
    import psd_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int HOLDOFF  = HOLDOFF_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] data_input,
    input  logic [DATA_W-1:0] trigger_threshold,
    output logic [DATA_W-1:0] baseline_value,
    output logic              baseline_valid,
    output logic              pulse_start,
    output logic              busy
);

    localparam int ACC_W = acc_width(DATA_W, AVG_LOG2);
    localparam int CNT_W = $clog2(HOLDOFF + 1);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   baseline_q, baseline_d;
    logic                baseline_valid_q, baseline_valid_d;
    logic                pulse_start_q, pulse_start_d;
    logic                busy_q, busy_d;

    logic [ACC_W-1:0]    acc_sum;
    logic [DATA_W-1:0]   block_avg;
    logic                block_done;
    logic [DATA_W:0]     trig_limit;
    logic                trig;

    logic                hold_cnt_clear;
    logic                hold_cnt_en;
    logic [CNT_W-1:0]    hold_cnt;
    logic                hold_flag;
    logic                hold_done;

    // Running sum, truncated block average, and the trigger compare; the compare is one
    // bit wider than the data so baseline + threshold can never wrap below a sample.
    always_comb begin
        acc_sum    = acc_q + ACC_W'(data_input);
        block_avg  = acc_sum[ACC_W-1:AVG_LOG2];
        block_done = (cnt_q == {AVG_LOG2{1'b1}});
        trig_limit = {1'b0, baseline_q} + {1'b0, trigger_threshold};
        trig       = (state_q == ST_TRACK) && sample_valid && ({1'b0, data_input} > trig_limit);
    end

    // Holdoff counter sits at zero outside HOLD; the trigger cycle counts as its first
    // step so the rollover flag lands on the HOLDOFF-th cycle of HOLD.
    always_comb begin
        hold_cnt_clear = (state_q != ST_HOLD) && !trig;
        hold_cnt_en    = trig || (state_q == ST_HOLD);
        hold_done      = hold_flag && (hold_cnt == CNT_W'(HOLDOFF));
    end

    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_hold_cnt (
        .clk           (clk),
        .nrst          (nrst),
        .clear         (hold_cnt_clear),
        .count_enable  (hold_cnt_en),
        .rollover_val  (CNT_W'(HOLDOFF)),
        .count_out     (hold_cnt),
        .rollover_flag (hold_flag)
    );

    // FSM next state: accumulate in FILL/TRACK, trigger out of TRACK, sit frozen in HOLD.
    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        cnt_d            = cnt_q;
        baseline_d       = baseline_q;
        baseline_valid_d = baseline_valid_q;
        pulse_start_d    = 1'b0;
        busy_d           = busy_q;
        case (state_q)
            ST_FILL, ST_TRACK: begin
                if (trig) begin
                    // Pulse wins over a block completing on the same sample; partial block is dropped.
                    acc_d         = '0;
                    cnt_d         = '0;
                    pulse_start_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = ST_HOLD;
                end else if (sample_valid) begin
                    if (block_done) begin
                        baseline_d       = block_avg;
                        baseline_valid_d = 1'b1;
                        acc_d            = '0;
                        cnt_d            = '0;
                        state_d          = ST_TRACK;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + AVG_LOG2'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (hold_done) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_TRACK;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // All tracker state and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q          <= ST_FILL;
            acc_q            <= '0;
            cnt_q            <= '0;
            baseline_q       <= '0;
            baseline_valid_q <= 1'b0;
            pulse_start_q    <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            cnt_q            <= cnt_d;
            baseline_q       <= baseline_d;
            baseline_valid_q <= baseline_valid_d;
            pulse_start_q    <= pulse_start_d;
            busy_q           <= busy_d;
        end
    end

    assign baseline_value = baseline_q;
    assign baseline_valid = baseline_valid_q;
    assign pulse_start    = pulse_start_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_psd_baseline_tracker.sv
// Scoreboard bench for psd_baseline_tracker: expected baseline updates and pulses are queued
// with the cycle they must appear in; a monitor pops and compares whenever the DUT shows one.
// Directed vectors with hand-computed values cover fill, tracking, trigger boundary, holdoff and reset.
module tb_psd_baseline_tracker;

    logic        clk;
    logic        nrst;
    logic        sample_valid;
    logic [19:0] data_input;
    logic [19:0] trigger_threshold;
    logic [19:0] baseline_value;
    logic        baseline_valid;
    logic        pulse_start;
    logic        busy;

    typedef struct {
        bit          is_pulse;
        logic [19:0] val;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [19:0] prev_base;
    logic        prev_bvld;
    int          busy_n;
    int          base_bad;

    psd_baseline_tracker #(
        .DATA_W   (20),
        .AVG_LOG2 (4),
        .HOLDOFF  (512)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .sample_valid      (sample_valid),
        .data_input        (data_input),
        .trigger_threshold (trigger_threshold),
        .baseline_value    (baseline_value),
        .baseline_valid    (baseline_valid),
        .pulse_start       (pulse_start),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One sample per clock: inputs applied, edge taken, return 1 time unit after the edge.
    task automatic send(input logic v, input logic [19:0] d);
        sample_valid = v;
        data_input   = d;
        @(posedge clk);
        #1;
    endtask

    // Queue an event that must be visible in the current (just-started) cycle.
    task automatic expect_evt(input bit p, input logic [19:0] v);
        exp_t e;
        e.is_pulse = p;
        e.val      = v;
        e.cyc      = cyc;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input bit p, input logic [19:0] v);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got pulse=%0d val=%0d at cycle %0d, expected no event", p, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_pulse != p || (!p && e.val !== v) || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got pulse=%0d val=%0d cycle=%0d, expected pulse=%0d val=%0d cycle=%0d",
                         p, v, cyc, e.is_pulse, e.val, e.cyc);
            end
        end
    endtask

    initial begin
        nrst              = 1'b0;
        sample_valid      = 1'b0;
        data_input        = '0;
        trigger_threshold = 20'd50;
        prev_base         = '0;
        prev_bvld         = 1'b0;

        // Monitor: a baseline event is valid rising or a value change; pulse_start is an event too.
        fork
            forever begin
                @(negedge clk);
                if (nrst) begin
                    if (baseline_valid && (!prev_bvld || baseline_value != prev_base))
                        pop_cmp(1'b0, baseline_value);
                    if (pulse_start)
                        pop_cmp(1'b1, 20'd0);
                end
                prev_base = baseline_value;
                prev_bvld = baseline_valid;
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_baseline", baseline_value, 0);
        chk("rst_valid", baseline_valid, 0);
        chk("rst_pulse", pulse_start, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk) nrst = 1'b1;

        // Initial fill: 16 x 1000 -> 1000
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 20'd1000);
            if (i == 14) chk("fill_valid_before_16th", baseline_valid, 0);
        end
        expect_evt(1'b0, 20'd1000);

        // Tracking: 16 x 1016 -> 1016
        for (int i = 0; i < 16; i++) send(1'b1, 20'd1016);
        expect_evt(1'b0, 20'd1016);

        // Truncation: 8 x 1017 + 8 x 1018 = 16280, /16 = 1017.5 -> 1017
        for (int i = 0; i < 16; i++) send(1'b1, (i % 2 == 1) ? 20'd1018 : 20'd1017);
        expect_evt(1'b0, 20'd1017);

        // Back to 1000 for the trigger boundary test, with one idle gap mid-block
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 20'd1000);
            if (i == 7) send(1'b0, 20'd9999);
        end
        expect_evt(1'b0, 20'd1000);

        // Boundary: 6 x 1000 + 1050 (equal to limit, no trigger) form a 7-sample partial block
        for (int i = 0; i < 6; i++) send(1'b1, 20'd1000);
        send(1'b1, 20'd1050);
        chk("no_trig_at_limit_busy", busy, 0);
        send(1'b1, 20'd1051);
        expect_evt(1'b1, 20'd0);
        chk("trig_busy", busy, 1);
        chk("trig_baseline_frozen", baseline_value, 1000);

        // Holdoff: HOLD cycle 1 is the current one; 511 more with toggling valid and a 4000 sample
        busy_n   = busy ? 1 : 0;
        base_bad = 0;
        for (int i = 0; i < 511; i++) begin
            send((i % 2) == 0, (i == 100) ? 20'd4000 : 20'd0);
            if (busy) busy_n++;
            if (baseline_value != 20'd1000) base_bad++;
        end
        send(1'b0, 20'd0);
        if (busy) busy_n++;
        chk("busy_cycles", busy_n, 512);
        chk("busy_low_after_hold", busy, 0);
        chk("baseline_during_hold", base_bad, 0);
        chk("valid_kept_after_hold", baseline_valid, 1);

        // Fresh block after HOLD: partial was discarded, so 16 x 1040 -> 1040
        for (int i = 0; i < 16; i++) send(1'b1, 20'd1040);
        expect_evt(1'b0, 20'd1040);

        // Overflow guard: baseline 0xFFFF0, threshold 0xFFFFF, sample 0xFFFFF must not trigger
        trigger_threshold = 20'hFFFFF;
        for (int i = 0; i < 16; i++) send(1'b1, 20'hFFFF0);
        expect_evt(1'b0, 20'hFFFF0);
        send(1'b1, 20'hFFFFF);
        send(1'b0, 20'd0);
        chk("overflow_no_trig_busy", busy, 0);

        // Threshold change takes effect immediately: 0xFFFFF > 0xFFFF0 + 5 triggers
        trigger_threshold = 20'd5;
        send(1'b1, 20'hFFFFF);
        expect_evt(1'b1, 20'd0);
        for (int i = 0; i < 199; i++) send(1'b0, 20'd0);
        chk("hold_cycle200_busy", busy, 1);

        // Asynchronous reset mid-HOLD
        #2 nrst = 1'b0;
        #1;
        chk("midrst_baseline", baseline_value, 0);
        chk("midrst_valid", baseline_valid, 0);
        chk("midrst_pulse", pulse_start, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk) nrst = 1'b1;

        // Full refill needed: 16 x 300 -> 300
        trigger_threshold = 20'd50;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 20'd300);
            if (i == 14) chk("refill_valid_before_16th", baseline_valid, 0);
        end
        expect_evt(1'b0, 20'd300);

        // FILL cannot trigger: 15 x 1000 + 5000 = 20000, /16 = 1250, and no pulse
        @(negedge clk) nrst = 1'b0;
        @(negedge clk) nrst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, (i == 7) ? 20'd5000 : 20'd1000);
            if (i == 7) chk("fill_5000_busy", busy, 0);
        end
        expect_evt(1'b0, 20'd1250);

        repeat (3) send(1'b0, 20'd0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
